uart_param: RTL and testbench

//  Full-duplex UART with compile-time frame format: 5-8 data bits, optional odd/even parity, 1 or 2 stop bits.

---
 rtl/uart_param_if.sv | 25 ++
 rtl/uart_param.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_param_if.sv
// Parallel-side bundle of the UART: transmit request/payload towards the
// core, received payload and per-frame status back out of it.
interface uart_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] I_DATA;
    logic                 send_data;
    logic                 TiP;
    logic [DATA_BITS-1:0] O_DATA;
    logic                 NrD;
    logic                 parity_err;
    logic                 frame_err;

    // Client side: requests transmissions and consumes received frames
    modport master (
        output I_DATA, send_data,
        input  TiP, O_DATA, NrD, parity_err, frame_err
    );

    // UART core side
    modport slave (
        input  I_DATA, send_data,
        output TiP, O_DATA, NrD, parity_err, frame_err
    );
endinterface

// File: rtl/uart_param.sv
// Full-duplex UART with a compile-time frame format (5..8 data bits, optional
// odd/even parity, 1 or 2 stop bits). The receiver synchronises Rx through two
// flops, samples mid-bit, rejects false starts and flags parity/framing errors.
module uart_param #(
    parameter int BAUD_DIVIDER = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic Rx,
    output logic Tx,
    uart_param_if.slave bus
);
    localparam int                CNT_W      = $clog2(BAUD_DIVIDER);
    localparam logic [CNT_W-1:0]  BAUD_LAST  = CNT_W'(BAUD_DIVIDER - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_PT  = CNT_W'(BAUD_DIVIDER / 2 - 1);
    localparam logic [3:0]        DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit                HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // Parity bit that accompanies a payload: even -> XOR, odd -> inverted XOR
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_bit_end;

    // TX next state: one bit per BAUD_DIVIDER cycles; Tx is registered with
    // the value of the bit the next state presents, so it lines up with TiP.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = 1'b1;
        tx_bit_end = (tx_cnt_q == BAUD_LAST);

        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (bus.send_data) begin
                    tx_state_d = TX_START;
                    tx_shift_d = bus.I_DATA;
                    tx_par_d   = parity_of(bus.I_DATA);
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = '0;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_shift_d[0];
            TX_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // TX state register; reset parks the line idle-high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign Tx      = tx_q;
    assign bus.TiP = (tx_state_q != TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_s1_q, rx_s2_q;
    logic rxs;

    // Two-flop synchroniser; idles high so reset does not look like a start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= Rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rxs = rx_s2_q;

    rx_state_t            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_bad_q, stop_bad_d;
    logic [DATA_BITS-1:0] o_data_q, o_data_d;
    logic                 nrd_q, nrd_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_sample;

    // RX next state: counter restarts on the start edge, samples at mid-bit,
    // and the frame completes on the final stop sample without waiting for
    // the bit to end so the next start edge is never missed.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        o_data_d   = o_data_q;
        nrd_d      = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        rx_sample  = (rx_cnt_q == SAMPLE_PT);

        if (rx_state_q != RX_IDLE && rx_state_q != RX_BREAK) begin
            rx_cnt_d = (rx_cnt_q == BAUD_LAST) ? '0 : rx_cnt_q + 1'b1;
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    rx_state_d = rxs ? RX_IDLE : RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rxs, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                        rx_bit_d   = '0;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    par_bad_d  = (rxs != parity_of(rx_shift_q));
                    rx_state_d = RX_STOP;
                    rx_bit_d   = '0;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    if (rx_bit_q == STOP_LAST) begin
                        nrd_d      = 1'b1;
                        o_data_d   = rx_shift_q;
                        perr_d     = par_bad_q;
                        ferr_d     = stop_bad_q | ~rxs;
                        rx_state_d = rxs ? RX_IDLE : RX_BREAK;
                    end else begin
                        stop_bad_d = stop_bad_q | ~rxs;
                        rx_bit_d   = rx_bit_q + 1'b1;
                    end
                end
            end
            RX_BREAK: begin
                if (rxs) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state and result registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            o_data_q   <= '0;
            nrd_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            o_data_q   <= o_data_d;
            nrd_q      <= nrd_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.O_DATA     = o_data_q;
    assign bus.NrD        = nrd_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an 8E1 instance (A) and a 7O2 instance (B), both with
// Tx looped back to Rx; A's Rx can also be driven directly with crafted frames.
module tb_uart_param;
    localparam int BAUD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       tx_a, tx_b, rx_a;
    logic       rx_drv   = 1'b1;
    logic       loop_a   = 1'b1;
    logic       sel      = 1'b0;
    logic       send_req = 1'b0;
    logic [7:0] din      = '0;
    logic       tx_s, tip_s;

    int total = 0;
    int bad   = 0;

    uart_param_if #(.DATA_BITS(8)) bus_a ();
    uart_param_if #(.DATA_BITS(7)) bus_b ();

    assign bus_a.I_DATA    = din;
    assign bus_b.I_DATA    = din[6:0];
    assign bus_a.send_data = send_req && !sel;
    assign bus_b.send_data = send_req && sel;
    assign rx_a            = loop_a ? tx_a : rx_drv;
    assign tx_s            = sel ? tx_b : tx_a;
    assign tip_s           = sel ? bus_b.TiP : bus_a.TiP;

    uart_param #(.BAUD_DIVIDER(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_a (
        .clk (clk), .rst (rst), .Rx (rx_a), .Tx (tx_a), .bus (bus_a)
    );

    uart_param #(.BAUD_DIVIDER(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
        .clk (clk), .rst (rst), .Rx (tx_b), .Tx (tx_b), .bus (bus_b)
    );

    // Received-frame log: {parity_err, frame_err, payload} per NrD cycle
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    always @(negedge clk) begin
        if (bus_a.NrD === 1'b1) q_a.push_back({bus_a.parity_err, bus_a.frame_err, bus_a.O_DATA});
        if (bus_b.NrD === 1'b1) q_b.push_back({bus_b.parity_err, bus_b.frame_err, 1'b0, bus_b.O_DATA});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time=%0t limit=2000000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int frame_len(input int db, input int par, input int sb);
        return 1 + db + int'(par != 0) + sb;
    endfunction

    // Line level of each frame bit, bit 0 = start bit
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int db, input int par);
        logic [15:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < db; i++) begin
            f[1 + i] = d[i];
            p        = p ^ d[i];
        end
        if (par != 0) f[1 + db] = (par == 1) ? ~p : p;
        return f;
    endfunction

    // What a correct receiver reports for a given line frame
    function automatic logic [9:0] decode(input logic [15:0] f, input int db, input int par, input int sb);
        logic [7:0] d;
        logic       p, pe, fe;
        d  = '0;
        pe = 1'b0;
        fe = 1'b0;
        for (int i = 0; i < db; i++) d[i] = f[1 + i];
        if (par != 0) begin
            p  = ^d;
            if (par == 1) p = ~p;
            pe = (f[1 + db] != p);
        end
        for (int s = 0; s < sb; s++) if (!f[1 + db + int'(par != 0) + s]) fe = 1'b1;
        return {pe, fe, d};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_send(input string tag, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (tip_s !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_wait"}, (n < 200), 1);
        din      = d;
        send_req = 1'b1;
        @(posedge clk);
        #1 send_req = 1'b0;
    endtask

    // Called just after the accept edge: records Tx/TiP over the whole frame
    task automatic capture_tx(input string tag, input logic [15:0] f, input int nb);
        logic [63:0] obs, expv;
        int          tip_n;
        obs   = '0;
        expv  = '0;
        tip_n = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < BAUD; c++) begin
                @(negedge clk);
                obs   = {obs[62:0], tx_s};
                expv  = {expv[62:0], f[b]};
                tip_n = tip_n + int'(tip_s);
            end
        end
        check({tag, "_tx_wave"}, obs, expv);
        check({tag, "_tip_len"}, tip_n, nb * BAUD);
        @(negedge clk);
        check({tag, "_tip_drop"}, tip_s, 1'b0);
    endtask

    task automatic rx_count(input string tag, input bit use_b, input int expn);
        check({tag, "_nrd_count"}, use_b ? q_b.size() : q_a.size(), expn);
    endtask

    task automatic rx_expect(input string tag, input bit use_b, input logic [9:0] expv);
        logic [9:0] got;
        int         n;
        n = use_b ? q_b.size() : q_a.size();
        check({tag, "_nrd_present"}, (n > 0), 1);
        if (n > 0) begin
            if (use_b) got = q_b.pop_front();
            else       got = q_a.pop_front();
            check({tag, "_rx_word"}, got, expv);
        end
    endtask

    // Loopback frame on the selected instance: waveform, TiP, then the echo
    task automatic loop_frame(input string tag, input bit use_b, input logic [7:0] d);
        int db  = use_b ? 7 : 8;
        int par = use_b ? 1 : 2;
        int sb  = use_b ? 2 : 1;
        logic [15:0] f;
        sel = use_b;
        f   = frame_bits(d, db, par);
        start_send(tag, d);
        capture_tx(tag, f, frame_len(db, par, sb));
        repeat (12) @(negedge clk);
        rx_count(tag, use_b, 1);
        rx_expect(tag, use_b, decode(f, db, par, sb));
    endtask

    // Drive a crafted frame straight into instance A's Rx
    task automatic drive_rx(input logic [15:0] f, input int nb);
        @(posedge clk);
        #1;
        for (int b = 0; b < nb; b++) begin
            rx_drv = f[b];
            repeat (BAUD) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    task automatic rx_frame_a(input string tag, input logic [15:0] f);
        drive_rx(f, 11);
        repeat (12) @(negedge clk);
        rx_count(tag, 1'b0, 1);
        rx_expect(tag, 1'b0, decode(f, 8, 2, 1));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] f;
        logic [7:0]  d;

        repeat (3) @(negedge clk);
        check("rst_tx_a", tx_a, 1'b1);
        check("rst_tip_a", bus_a.TiP, 1'b0);
        check("rst_nrd_a", bus_a.NrD, 1'b0);
        check("rst_odata_a", bus_a.O_DATA, 8'h00);
        check("rst_errs_a", {bus_a.parity_err, bus_a.frame_err}, 2'b00);
        check("rst_tx_b", tx_b, 1'b1);
        check("rst_tip_b", bus_b.TiP, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        loop_a = 1'b1;
        loop_frame("t1_0B", 1'b0, 8'h0B);

        // Back-to-back frames under a held request; I_DATA changed mid-frame
        sel = 1'b0;
        start_send("t2_first", 8'h55);
        send_req = 1'b1;
        din      = 8'hA3;
        capture_tx("t2_55", frame_bits(8'h55, 8, 2), 11);
        @(posedge clk);
        #1 send_req = 1'b0;
        capture_tx("t2_A3", frame_bits(8'hA3, 8, 2), 11);
        repeat (12) @(negedge clk);
        rx_count("t2", 1'b0, 2);
        rx_expect("t2_55", 1'b0, {2'b00, 8'h55});
        rx_expect("t2_A3", 1'b0, {2'b00, 8'hA3});

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            loop_frame("rnd_loop_a", 1'b0, d);
        end

        loop_a = 1'b0;
        f = frame_bits(8'h3C, 8, 2);
        f[9] = ~f[9];
        rx_frame_a("t3_par", f);

        // Stop bit low and line held low 20 cycles: exactly one NrD
        f = frame_bits(8'h81, 8, 2);
        f[10] = 1'b0;
        drive_rx(f, 10);
        rx_drv = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (12) @(negedge clk);
        rx_count("t4_break", 1'b0, 1);
        rx_expect("t4_break", 1'b0, {2'b01, 8'h81});
        rx_frame_a("t4_42", frame_bits(8'h42, 8, 2));

        // One-cycle glitch while idle must not produce a frame
        @(posedge clk);
        #1 rx_drv = 1'b0;
        @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        rx_count("t5_glitch", 1'b0, 0);
        rx_frame_a("t5_7E", frame_bits(8'h7E, 8, 2));

        for (int i = 0; i < 5; i++) begin
            f = frame_bits(8'($urandom), 8, 2);
            if ($urandom_range(0, 2) == 0) f[9]  = ~f[9];
            if ($urandom_range(0, 2) == 0) f[10] = 1'b0;
            rx_frame_a("rnd_rx_a", f);
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end

        // Reset during data bit 3 of a loopback frame
        loop_a = 1'b1;
        sel    = 1'b0;
        f = frame_bits(8'h96, 8, 2);
        start_send("t6", 8'h96);
        repeat (17) @(posedge clk);
        #1 check("t6_mid_bit3", tx_a, f[4]);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_tx", tx_a, 1'b1);
        check("t6_rst_tip", bus_a.TiP, 1'b0);
        check("t6_rst_odata", bus_a.O_DATA, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        rx_count("t6_no_nrd", 1'b0, 0);
        check("t6_tx_idle", tx_a, 1'b1);

        loop_frame("t6_7O2_2A", 1'b1, 8'h2A);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom) & 8'h7F;
            loop_frame("rnd_loop_b", 1'b1, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
